// File: rtl/detector_sched_pkg.sv
// Shared types and defaults for the detector scheduler slice.
package detector_sched_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr_last remembers the most recent winner.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic rr_last;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        gnt0 = en & req0 & (~req1 | rr_last);
        gnt1 = en & req1 & (~req0 | ~rr_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (gnt0) begin
            rr_last <= 1'b0;
        end else if (gnt1) begin
            rr_last <= 1'b1;
        end
    end

endmodule

// File: rtl/detector_scheduler.sv
// Time-shares one serial Mealy detector between two parallel-word requesters
// and returns the per-word detection count with the owner ID.
module detector_scheduler
    import detector_sched_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic             det_rst,
    output logic             det_en,
    output logic             det_serIn,
    input  logic             det_detect,
    output logic             done,
    output logic [CNT_W-1:0] result_cnt,
    output logic             result_id
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   result_cnt_q;
    logic               result_id_q;
    logic               id;
    logic               gnt0;
    logic               gnt1;
    logic               last_bit;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (~rst && (state == IDLE)),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // Saturating increment on a detect pulse; never wraps.
    always_comb begin
        cnt_nxt = cnt;
        if (det_detect && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            id           <= 1'b0;
            bit_cnt      <= '0;
            cnt          <= '0;
            result_cnt_q <= '0;
            result_id_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        shreg <= gnt1 ? data1 : data0;
                        id    <= gnt1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    bit_cnt <= '0;
                    cnt     <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    cnt     <= cnt_nxt;
                    // Result is captured with the last bit's detect included.
                    if (last_bit) begin
                        result_cnt_q <= cnt_nxt;
                        result_id_q  <= id;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state; rst forces everything quiet except det_rst.
    assign ack0       = gnt0;
    assign ack1       = gnt1;
    assign det_rst    = rst | (state == CLEAR);
    assign det_en     = ~rst & (state == SHIFT);
    assign det_serIn  = det_en & shreg[WIDTH-1];
    assign done       = ~rst & (state == DONE);
    assign result_cnt = rst ? '0 : result_cnt_q;
    assign result_id  = ~rst & result_id_q;

endmodule

// File: tb/tb_detector_scheduler.sv
// Directed bench: default-width scheduler plus a CNT_W=2 copy driven in lockstep.
module tb_detector_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = '0;
    logic [7:0] data1 = '0;
    logic       stub_det = 1'b0;
    logic       use_real = 1'b0;
    logic       prev_bit = 1'b0;
    logic       det_detect;

    logic       ack0, ack1, det_rst, det_en, det_serIn, done, result_id;
    logic [3:0] result_cnt;
    logic       s_ack0, s_ack1, s_det_rst, s_det_en, s_ser, s_done, s_id;
    logic [1:0] s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference "11" Mealy detector, selectable in place of the scripted stub.
    always @(posedge clk) begin
        if (det_rst) prev_bit <= 1'b0;
        else if (det_en) prev_bit <= det_serIn;
    end
    assign det_detect = use_real ? (det_en & det_serIn & prev_bit) : stub_det;

    detector_scheduler #(.WIDTH(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .det_rst(det_rst), .det_en(det_en), .det_serIn(det_serIn),
        .det_detect(det_detect),
        .done(done), .result_cnt(result_cnt), .result_id(result_id)
    );

    detector_scheduler #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(s_ack0),
        .req1(req1), .data1(data1), .ack1(s_ack1),
        .det_rst(s_det_rst), .det_en(s_det_en), .det_serIn(s_ser),
        .det_detect(det_detect),
        .done(s_done), .result_cnt(s_cnt), .result_id(s_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        cyc();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; stub_det = 1'b0; use_real = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_det_rst", det_rst, 1);
            chk("rst_quiet", {ack0, ack1, det_en, det_serIn, done, result_id}, 0);
            chk("rst_cnt", result_cnt, 0);
            cyc();
        end
        rst = 1'b0;
        #1;
        chk("post_rst_det_rst", det_rst, 0);
        chk("post_rst_quiet", {ack0, ack1, det_en, det_serIn, done, result_id}, 0);
        chk("post_rst_cnt", result_cnt, 0);
    endtask

    // Called in the grant cycle with the request already raised; returns one
    // cycle after the done pulse (IDLE), where a pending request may be granted.
    task automatic serve(input int who, input logic [7:0] word, input logic [7:0] mask,
                         input logic noise, input int exp_cnt);
        int exp_sat;
        exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;
        #1;
        chk("ack_hit", (who == 0) ? ack0 : ack1, 1);
        chk("ack_other", (who == 0) ? ack1 : ack0, 0);
        chk("sat_ack", (who == 0) ? s_ack0 : s_ack1, 1);
        chk("idle_en", det_en, 0);
        cyc();
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        stub_det = noise;
        #1;
        chk("clear_rst", det_rst, 1);
        chk("sat_clear_rst", s_det_rst, 1);
        chk("clear_en_ser", {det_en, det_serIn}, 0);
        chk("clear_noack", {ack0, ack1}, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            stub_det = mask[i];
            #1;
            chk("shift_en", det_en, 1);
            chk("shift_bit", det_serIn, word[7-i]);
            chk("shift_det_rst", det_rst, 0);
            chk("sat_shift", {s_det_en, s_ser}, {1'b1, word[7-i]});
        end
        cyc();
        stub_det = noise;
        #1;
        chk("done_pulse", done, 1);
        chk("done_cnt", result_cnt, exp_cnt);
        chk("done_id", result_id, who);
        chk("done_en_ser", {det_en, det_serIn}, 0);
        chk("done_noack", {ack0, ack1}, 0);
        chk("sat_done", s_done, 1);
        chk("sat_cnt", s_cnt, exp_sat);
        chk("sat_id", s_id, who);
        cyc();
        stub_det = 1'b0;
        #1;
        chk("done_one_cycle", done, 0);
        chk("hold_cnt", result_cnt, exp_cnt);
        chk("hold_id", result_id, who);
    endtask

    initial begin
        // 1: reset behaviour
        apply_reset();

        // 2: single requester, stub detects at bits 3 and 5
        data0 = 8'b0111_1100; req0 = 1'b1;
        serve(0, 8'b0111_1100, 8'b0010_1000, 1'b0, 2);

        // 3: simultaneous requests after reset, req0 first then req1 (11 cycles apart)
        apply_reset();
        data0 = 8'hA5; data1 = 8'h3C; req0 = 1'b1; req1 = 1'b1;
        serve(0, 8'hA5, 8'h01, 1'b0, 1);
        serve(1, 8'h3C, 8'h81, 1'b0, 2);

        // 3b/4: both again -> req0 wins; detect held every bit saturates the CNT_W=2 copy
        data0 = 8'h5A; data1 = 8'hC3; req0 = 1'b1; req1 = 1'b1;
        serve(0, 8'h5A, 8'hFF, 1'b0, 8);
        serve(1, 8'hC3, 8'h00, 1'b0, 0);

        // 6: detect asserted only outside SHIFT is ignored
        data0 = 8'hFF; req0 = 1'b1; stub_det = 1'b1;
        serve(0, 8'hFF, 8'h00, 1'b1, 0);

        // Real "11" detector on 1110_1101 -> hits at stream bits 1,2,5
        use_real = 1'b1;
        data1 = 8'b1110_1101; req1 = 1'b1;
        serve(1, 8'b1110_1101, 8'h00, 1'b0, 3);
        use_real = 1'b0;

        // 5: reset during the 4th SHIFT cycle, then the held req1 is acked cleanly
        apply_reset();
        data0 = 8'hF0; req0 = 1'b1;
        #1;
        chk("abort_ack0", ack0, 1);
        cyc();
        req0 = 1'b0; data1 = 8'h81; req1 = 1'b1;
        #1;
        chk("abort_clear", det_rst, 1);
        chk("abort_wait", ack1, 0);
        repeat (3) cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("abort_rst_quiet", {det_en, done, ack0, ack1}, 0);
        chk("abort_rst_det_rst", det_rst, 1);
        cyc();
        rst = 1'b0;
        #1;
        chk("abort_idle_en", det_en, 0);
        chk("abort_no_done", done, 0);
        chk("abort_cnt", result_cnt, 0);
        serve(1, 8'h81, 8'h00, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
